// File: rtl/sext_rr_arbiter_if.sv
// Bundle of requester-side and consumer-side signals for the shared sign/zero-extension arbiter.
// The slave modport is the arbiter's view and the master modport is the producer/consumer view.
interface sext_rr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 8,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) ();
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_zext;
    logic [NREQ*IN_W-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out_data;
    logic [ID_W-1:0]      out_id;
    logic [CNT_W-1:0]     xfer_cnt;

    modport slave (
        input  req_valid,
        input  req_zext,
        input  req_data,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_data,
        output out_id,
        output xfer_cnt
    );

    modport master (
        output req_valid,
        output req_zext,
        output req_data,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_data,
        input  out_id,
        input  xfer_cnt
    );
endinterface

// File: rtl/sext_rr_arbiter.sv
// Round-robin arbiter that shares a single IN_W->OUT_W sign/zero-extension datapath among NREQ
// requesters, feeding a single registered output slot with valid/ready backpressure.
module sext_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 8,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             areset_n,
    sext_rr_arbiter_if.slave bus
);
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW    = ID_W + 1;
    localparam int PAD_W = OUT_W - IN_W;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_q,    state_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [ID_W-1:0]  out_id_q,   out_id_d;
    logic [ID_W-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic [OUT_W-1:0] ext_data [NREQ];
    logic [ID_W-1:0]  grant_idx;
    logic             grant_found;
    logic             can_load;
    logic             accept;
    logic [NREQ-1:0]  req_ready_w;

    // Every requester's operand is extended in parallel; the grant only selects one result.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ext
            logic [IN_W-1:0] d;
            assign d = bus.req_data[gi*IN_W +: IN_W];
            assign ext_data[gi] = bus.req_zext[gi] ? {{PAD_W{1'b0}}, d}
                                                   : {{PAD_W{d[IN_W-1]}}, d};
        end
    endgenerate

    // Scan starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        logic [CW-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!grant_found && bus.req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign can_load = (state_q == ST_EMPTY) || bus.out_ready;
    // Gated by areset_n so no requester sees an accept while reset is held.
    assign accept   = grant_found && can_load && areset_n;

    always_comb begin
        req_ready_w = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready_w[i] = accept && (grant_idx == ID_W'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!accept && bus.out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (accept) begin
            out_data_d = ext_data[grant_idx];
            out_id_d   = grant_idx;
            rr_ptr_d   = grant_idx;
            cnt_d      = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            out_id_q   <= '0;
            rr_ptr_q   <= ID_W'(NREQ - 1);
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.req_ready = req_ready_w;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
    assign bus.xfer_cnt  = cnt_q;

endmodule
